// File: rtl/seven_seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the FSM state encoding, default sizing and the dwell counter width helper.
package seven_seg_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

  // Dwell counter needs at least one bit even when the dwell is a single cycle.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : int'($clog2(n));
    return w;
  endfunction

endpackage

// File: rtl/seven_seg_display_arbiter_picker.sv
// Rotating first-set search: scans mask from start, wrapping, and reports the first hit.
module round_robin_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  winner_c,
  output logic [IW-1:0] index_c,
  output logic          found_c
);

  int unsigned      pos;
  logic [IW-1:0]    pos_idx;

  always_comb begin
    winner_c = '0;
    index_c  = '0;
    found_c  = 1'b0;
    pos      = 0;
    pos_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(start) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IW'(pos);
      if (!found_c && mask[pos_idx]) begin
        found_c           = 1'b1;
        winner_c[pos_idx] = 1'b1;
        index_c           = pos_idx;
      end
    end
  end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Time-shares one seven-segment display between several requesters.
// Round-robin ownership with a dwell timer, urgent preemption and registered display outputs.
module seven_seg_display_arbiter
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        urgent,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_mode,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         display_number,
  output logic                      display_mode,
  output logic                      display_valid
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = cnt_width(DWELL_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic [DATA_W-1:0]   number_q, number_d;
  logic                mode_q, mode_d;
  logic                valid_q, valid_d;

  logic [NUM_REQ-1:0]  req_urg_c;
  logic [IDX_W-1:0]    start_c;
  logic [NUM_REQ-1:0]  rr_oh_c, urg_oh_c, pick_oh_c;
  logic [IDX_W-1:0]    rr_idx_c, urg_idx_c, pick_idx_c;
  logic                rr_found_c, urg_found_c, pick_found_c;
  logic                owner_req_c, owner_urg_c, others_req_c, others_urg_c;
  logic                expiry_c, preempt_c;

  assign req_urg_c = req & urgent;
  assign start_c   = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + IDX_W'(1);

  round_robin_picker #(.N(NUM_REQ), .IW(IDX_W)) u_pick_rr (
    .mask     (req),
    .start    (start_c),
    .winner_c (rr_oh_c),
    .index_c  (rr_idx_c),
    .found_c  (rr_found_c)
  );

  round_robin_picker #(.N(NUM_REQ), .IW(IDX_W)) u_pick_urg (
    .mask     (req_urg_c),
    .start    (start_c),
    .winner_c (urg_oh_c),
    .index_c  (urg_idx_c),
    .found_c  (urg_found_c)
  );

  // Urgent requesters take precedence over the plain rotation.
  assign pick_oh_c    = urg_found_c ? urg_oh_c  : rr_oh_c;
  assign pick_idx_c   = urg_found_c ? urg_idx_c : rr_idx_c;
  assign pick_found_c = urg_found_c | rr_found_c;

  assign owner_req_c  = |(req & grant_q);
  assign owner_urg_c  = |(req_urg_c & grant_q);
  assign others_req_c = |(req & ~grant_q);
  assign others_urg_c = |(req_urg_c & ~grant_q);
  assign expiry_c     = (cnt_q == DWELL_LAST);
  assign preempt_c    = !owner_urg_c && others_urg_c;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    number_d     = number_q;
    mode_d       = mode_q;

    unique case (state_q)
      ST_IDLE, ST_SWITCH: begin
        grant_d = '0;
        cnt_d   = '0;
        if (pick_found_c) begin
          state_d      = ST_SHOW;
          grant_d      = pick_oh_c;
          last_owner_d = pick_idx_c;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (!owner_req_c || preempt_c || (expiry_c && others_req_c)) begin
          state_d = ST_SWITCH;
          grant_d = '0;
          cnt_d   = '0;
        end else if (expiry_c) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Display follows whoever owns the display after this edge; holds otherwise.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) begin
        number_d = req_data[i*DATA_W +: DATA_W];
        mode_d   = req_mode[i];
      end
    end
    valid_d = |grant_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      cnt_q        <= '0;
      last_owner_q <= LAST_IDX;
      number_q     <= '0;
      mode_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      number_q     <= number_d;
      mode_q       <= mode_d;
      valid_q      <= valid_d;
    end
  end

  assign grant          = grant_q;
  assign display_number = number_q;
  assign display_mode   = mode_q;
  assign display_valid  = valid_q;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed self-checking bench for seven_seg_display_arbiter (NUM_REQ=4, DWELL_CYCLES=8).
module tb_seven_seg_display_arbiter;

  logic         clock;
  logic         reset_n;
  logic [3:0]   req;
  logic [3:0]   urgent;
  logic [127:0] req_data;
  logic [3:0]   req_mode;
  logic [3:0]   grant;
  logic [31:0]  display_number;
  logic         display_mode;
  logic         display_valid;

  int checks;
  int passes;

  seven_seg_display_arbiter #(
    .NUM_REQ      (4),
    .DATA_W       (32),
    .DWELL_CYCLES (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .urgent         (urgent),
    .req_data       (req_data),
    .req_mode       (req_mode),
    .grant          (grant),
    .display_number (display_number),
    .display_mode   (display_mode),
    .display_valid  (display_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req      = '0;
    urgent   = '0;
    req_data = '0;
    req_mode = '0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    req      = 4'b1111;
    urgent   = '0;
    req_data = {4{32'hFFFF_FFFF}};
    req_mode = 4'b1111;
    step(2);
    checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant); else passes++;
    checks++; if (display_number !== 32'h0) $display("FAIL reset_number got=%h exp=0", display_number); else passes++;
    checks++; if (display_mode !== 1'b0) $display("FAIL reset_mode got=%b exp=0", display_mode); else passes++;
    checks++; if (display_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", display_valid); else passes++;
  endtask

  task automatic test_single_owner();
    do_reset();
    req = 4'b0001;
    set_data(0, 32'h1234);
    step(1);
    checks++; if (grant !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", grant); else passes++;
    checks++; if (display_number !== 32'h1234) $display("FAIL single_number got=%h exp=1234", display_number); else passes++;
    checks++; if (display_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", display_valid); else passes++;
    set_data(0, 32'h5678);
    step(1);
    checks++; if (display_number !== 32'h5678) $display("FAIL single_refresh got=%h exp=5678", display_number); else passes++;
    // Sole requester keeps the display across several dwell periods.
    step(17);
    checks++; if (grant !== 4'b0001) $display("FAIL single_hold got=%b exp=0001", grant); else passes++;
    // At observation 19 the count is 2; competitor appears, expiry lands on observation 24.
    req = 4'b0011;
    step(5);
    checks++; if (grant !== 4'b0001) $display("FAIL single_before_expiry got=%b exp=0001", grant); else passes++;
    step(1);
    checks++; if (grant !== 4'b0000) $display("FAIL single_switch got=%b exp=0000", grant); else passes++;
    step(1);
    checks++; if (grant !== 4'b0010) $display("FAIL single_next_owner got=%b exp=0010", grant); else passes++;
  endtask

  task automatic test_rotation();
    int seq [4];
    int ph;
    int own;
    logic [3:0]  exp_g;
    logic [31:0] exp_n;
    seq = '{0, 1, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 32'h0000_00A0 + 32'(i));
    req = 4'b1011;
    for (int t = 1; t <= 28; t++) begin
      step(1);
      ph  = (t - 1) % 9;
      own = seq[(t - 1) / 9];
      exp_g = '0;
      if (ph != 8) exp_g[own] = 1'b1;
      exp_n = 32'h0000_00A0 + 32'(own);
      checks++;
      if (grant !== exp_g) $display("FAIL rotate_grant t=%0d got=%b exp=%b", t, grant, exp_g); else passes++;
      checks++;
      if (display_valid !== (ph != 8)) $display("FAIL rotate_valid t=%0d got=%b exp=%b", t, display_valid, (ph != 8)); else passes++;
      if (ph != 8) begin
        checks++;
        if (display_number !== exp_n) $display("FAIL rotate_number t=%0d got=%h exp=%h", t, display_number, exp_n); else passes++;
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    set_data(0, 32'h0000_0A0A);
    set_data(2, 32'h0000_2C2C);
    req_mode = 4'b0100;
    req = 4'b0001;
    step(4);
    checks++; if (grant !== 4'b0001) $display("FAIL preempt_setup got=%b exp=0001", grant); else passes++;
    req    = 4'b0101;
    urgent = 4'b0100;
    step(1);
    checks++; if (grant !== 4'b0000) $display("FAIL preempt_switch got=%b exp=0000", grant); else passes++;
    step(1);
    checks++; if (grant !== 4'b0100) $display("FAIL preempt_grant got=%b exp=0100", grant); else passes++;
    checks++; if (display_mode !== 1'b1) $display("FAIL preempt_mode got=%b exp=1", display_mode); else passes++;
    checks++; if (display_number !== 32'h2C2C) $display("FAIL preempt_number got=%h exp=2c2c", display_number); else passes++;
    // Urgent owner is not displaced by another urgent requester.
    urgent = 4'b0101;
    step(3);
    checks++; if (grant !== 4'b0100) $display("FAIL urgent_owner_kept got=%b exp=0100", grant); else passes++;
  endtask

  task automatic test_drop();
    do_reset();
    set_data(1, 32'h0000_CAFE);
    req = 4'b0010;
    step(6);
    checks++; if (grant !== 4'b0010) $display("FAIL drop_setup got=%b exp=0010", grant); else passes++;
    req = 4'b0000;
    step(1);
    checks++; if (grant !== 4'b0000) $display("FAIL drop_switch_grant got=%b exp=0000", grant); else passes++;
    checks++; if (display_valid !== 1'b0) $display("FAIL drop_switch_valid got=%b exp=0", display_valid); else passes++;
    step(1);
    checks++; if (display_valid !== 1'b0) $display("FAIL drop_idle_valid got=%b exp=0", display_valid); else passes++;
    checks++; if (display_number !== 32'hCAFE) $display("FAIL drop_hold_number got=%h exp=cafe", display_number); else passes++;
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    set_data(2, 32'h0000_BEEF);
    req_mode = 4'b0100;
    req = 4'b0100;
    step(3);
    checks++; if (grant !== 4'b0100) $display("FAIL midrst_setup got=%b exp=0100", grant); else passes++;
    reset_n = 1'b0;
    step(1);
    checks++; if (grant !== 4'b0000) $display("FAIL midrst_grant got=%b exp=0000", grant); else passes++;
    checks++; if (display_number !== 32'h0) $display("FAIL midrst_number got=%h exp=0", display_number); else passes++;
    checks++; if (display_mode !== 1'b0) $display("FAIL midrst_mode got=%b exp=0", display_mode); else passes++;
    checks++; if (display_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", display_valid); else passes++;
    reset_n = 1'b1;
    step(1);
    checks++; if (grant !== 4'b0100) $display("FAIL midrst_regrant got=%b exp=0100", grant); else passes++;
    checks++; if (display_number !== 32'hBEEF) $display("FAIL midrst_renumber got=%h exp=beef", display_number); else passes++;
  endtask

  task automatic test_random_invariants();
    int bad_onehot;
    int bad_valid;
    bad_onehot = 0;
    bad_valid  = 0;
    do_reset();
    for (int t = 0; t < 10000; t++) begin
      req    = 4'($urandom);
      urgent = 4'($urandom);
      step(1);
      checks++;
      if (!$onehot0(grant)) begin
        if (bad_onehot < 5) $display("FAIL rand_onehot t=%0d got=%b exp=onehot0", t, grant);
        bad_onehot++;
      end else passes++;
      checks++;
      if (display_valid !== (|grant)) begin
        if (bad_valid < 5) $display("FAIL rand_valid t=%0d got=%b exp=%b", t, display_valid, |grant);
        bad_valid++;
      end else passes++;
    end
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    reset_n  = 1'b0;
    req      = '0;
    urgent   = '0;
    req_data = '0;
    req_mode = '0;
    test_reset();
    test_single_owner();
    test_rotation();
    test_preempt();
    test_drop();
    test_reset_mid_show();
    test_random_invariants();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_arbiter.md
SEVEN_SEG_DISPLAY_ARBITER -- requirements
Module: seven_seg_display_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the display.
REQ-002 SHALL have parameter DATA_W, default 32, width of each requester's number (matches the display driver's input_number).
REQ-003 SHALL have parameter DWELL_CYCLES, default 100_000_000, clocks a non-urgent owner holds the display before rotation.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  level request per requester.
REQ-007 SHALL have port urgent  input  NUM_REQ  preemption qualifier; ignored unless matching req bit set.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_W  requester i's number in bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_mode  input  NUM_REQ  requester i's display mode bit.
REQ-010 SHALL have port grant  output  NUM_REQ  one-hot (or zero) current owner.
REQ-011 SHALL have port display_number  output  DATA_W  to driver input_number.
REQ-012 SHALL have port display_mode  output  1  to driver mode.
REQ-013 SHALL have port display_valid  output  1  high while an owner exists.

Function
REQ-014 SHALL implement states IDLE (no owner), SHOW (owner held, dwell counting), SWITCH (one cycle, choose next owner).
REQ-015 IDLE: any req bit set -> SHOW next cycle with grant = winner of round-robin pick; else remain IDLE.
REQ-016 Round-robin pick SHALL search starting at (last_owner+1) mod NUM_REQ, wrapping, first set req bit wins.
REQ-017 Urgent pick SHALL override round-robin: among req&urgent, same rotating search order applies.
REQ-018 In SHOW, display_number/display_mode SHALL be registered copies of owner's req_data/req_mode, 1-cycle latency, refreshed every cycle.
REQ-019 Dwell counter SHALL clear on entering SHOW, increment each SHOW cycle; expiry when count reaches DWELL_CYCLES-1.
REQ-020 At expiry: if another requester has req set -> SWITCH; else if owner still requests -> counter clears, owner retained.
REQ-021 Owner dropping req in SHOW -> SWITCH next cycle; grant SHALL deassert in SWITCH.
REQ-022 Non-urgent owner SHALL be preempted (-> SWITCH next cycle) when any other req&urgent bit is set; an urgent owner SHALL not be preempted.
REQ-023 SWITCH: no req set -> IDLE, display_valid=0, display_number held at last value; else -> SHOW with newly picked owner.
REQ-024 Simultaneous expiry and owner drop SHALL behave as owner drop; simultaneous preemption and expiry SHALL pick urgent requester.
REQ-025 grant SHALL never have more than one bit set; display_valid SHALL equal |grant.
REQ-026 DWELL_CYCLES=1 SHALL rotate every SHOW cycle when competitors exist.

Reset
REQ-027 reset_n low at a rising edge SHALL force IDLE, grant=0, display_number=0, display_mode=0, display_valid=0, dwell count=0, last_owner=NUM_REQ-1 (first pick searches from 0).
REQ-028 Reset mid-SHOW SHALL take effect that edge; no partial dwell survives.

Structure
REQ-029 Package seven_seg_pkg SHALL hold the state enum, default NUM_REQ/DATA_W constants, and the dwell counter width function (clog2).
REQ-030 Search logic SHALL be one sub-module, round_robin_picker (inputs mask, start pointer; outputs one-hot winner, index, found), instantiated twice (normal, urgent).
REQ-031 No other sub-modules; total RTL 120-400 lines.

Verification (NUM_REQ=4, DWELL_CYCLES=8)
REQ-032 Reset then req=4'b0001, req_data[31:0]=32'h1234 -> next cycle grant=0001, display_number=32'h1234, display_valid=1; holds indefinitely with counter restarting every 8 cycles.
REQ-033 req=4'b1011 steady -> owners rotate 0,1,3,0 each 8 SHOW cycles plus 1 SWITCH cycle (grant=0 there).
REQ-034 Owner 0 in SHOW at count 3; urgent=4'b0100, req=4'b0101 -> SWITCH next cycle, then grant=0100, display_mode=req_mode[2].
REQ-035 Owner 1 drops req at count 5 with req=4'b0000 -> SWITCH, then IDLE, display_valid=0, display_number holds last value.
REQ-036 reset_n low for one cycle during SHOW owner 2 -> all outputs zero next edge; after release with req=4'b0100, grant=0100 after 1 cycle.
REQ-037 Checker: grant one-hot-or-zero and display_valid==|grant every cycle for 10,000 random req/urgent cycles.
